// File: rtl/interrupt_controller_pkg.sv
// Shared constants and FSM state type for the interrupt controller.
package interrupt_controller_pkg;

  localparam logic [5:0] IMSK_ADDR_DEFAULT = 6'h39;
  localparam logic [5:0] IFR_ADDR_DEFAULT  = 6'h38;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_REQUEST = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_priority_enc.sv
// Lowest-index-wins priority encoder over the 8-bit pending set.
module irq_priority_enc (
  input  logic [7:0] pend,
  output logic       valid,
  output logic [2:0] idx
);

  // Scan from the top down so the lowest set bit is the last to assign.
  always_comb begin
    valid = |pend;
    idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pend[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-latched, maskable, fixed-priority interrupt controller with a
// request/service handshake and I/O-mapped IMSK/IFR registers.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int          NUM_IRQ     = 8,
  parameter logic [11:0] VECTOR_BASE = 12'h001,
  parameter logic [5:0]  IMSK_ADDR   = IMSK_ADDR_DEFAULT,
  parameter logic [5:0]  IFR_ADDR    = IFR_ADDR_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_lines,
  input  logic               sreg_i,
  input  logic               irq_ack,
  input  logic               reti,
  input  logic [5:0]         io_addr,
  input  logic               io_wr,
  input  logic [7:0]         io_wdata,
  output logic [7:0]         io_rdata,
  output logic               irq,
  output logic [11:0]        vector,
  output logic               in_service
);

  localparam logic [8:0] MASK9     = (9'd1 << NUM_IRQ) - 9'd1;
  localparam logic [7:0] LINE_MASK = MASK9[7:0];

  logic [NUM_IRQ-1:0] line_q;
  logic [7:0]         ifr;
  logic [7:0]         imsk;
  logic [7:0]         rise;
  logic [7:0]         sw_clr;
  logic [7:0]         ack_clr;
  logic [7:0]         pend;
  logic               win_valid;
  logic [2:0]         win_idx;
  logic [2:0]         idx_q;
  irq_state_t         state;

  always_comb begin
    rise = '0;
    rise[NUM_IRQ-1:0] = irq_lines & ~line_q;
  end

  assign sw_clr  = (io_wr && io_addr == IFR_ADDR) ? io_wdata : 8'd0;
  assign ack_clr = (state == IRQ_REQUEST && irq_ack) ? (8'd1 << idx_q) : 8'd0;
  assign pend    = ifr & imsk;

  irq_priority_enc u_enc (
    .pend  (pend),
    .valid (win_valid),
    .idx   (win_idx)
  );

  // New edges are OR'd in after clears so a simultaneous set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_q <= irq_lines;
      ifr    <= '0;
      imsk   <= '0;
    end else begin
      line_q <= irq_lines;
      ifr    <= ((ifr & ~sw_clr & ~ack_clr) | rise) & LINE_MASK;
      if (io_wr && io_addr == IMSK_ADDR) imsk <= io_wdata & LINE_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IRQ_IDLE;
      idx_q      <= '0;
      irq        <= 1'b0;
      vector     <= '0;
      in_service <= 1'b0;
    end else begin
      case (state)
        IRQ_IDLE: begin
          if (sreg_i && win_valid) begin
            state  <= IRQ_REQUEST;
            idx_q  <= win_idx;
            vector <= VECTOR_BASE + {9'd0, win_idx};
            irq    <= 1'b1;
          end
        end
        IRQ_REQUEST: begin
          if (irq_ack) begin
            state      <= IRQ_SERVICE;
            irq        <= 1'b0;
            in_service <= 1'b1;
          end
        end
        IRQ_SERVICE: begin
          if (reti) begin
            state      <= IRQ_IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= IRQ_IDLE;
          irq        <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    io_rdata = 8'd0;
    if (io_addr == IMSK_ADDR)     io_rdata = imsk;
    else if (io_addr == IFR_ADDR) io_rdata = ifr;
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Randomized and directed bench for interrupt_controller against a
// cycle-level behavioural model of flags, mask and the request handshake.
module tb_interrupt_controller;

  logic        clk;
  logic        reset;
  logic [7:0]  irq_lines;
  logic        sreg_i;
  logic        irq_ack;
  logic        reti;
  logic [5:0]  io_addr;
  logic        io_wr;
  logic [7:0]  io_wdata;
  logic [7:0]  io_rdata;
  logic        irq;
  logic [11:0] vector;
  logic        in_service;

  logic [7:0]  io_rdata4;
  logic        irq4;
  logic [11:0] vector4;
  logic        in_service4;

  int tests_run;
  int tests_failed;

  // Model state: flag/mask bits, previous lines, and the handshake phase.
  bit   m_flag[8];
  bit   m_mask[8];
  bit   m_prev[8];
  bit   m_irq;
  bit   m_svc;
  int   m_idx;
  int   m_vec;

  interrupt_controller dut (
    .clk        (clk),
    .reset      (reset),
    .irq_lines  (irq_lines),
    .sreg_i     (sreg_i),
    .irq_ack    (irq_ack),
    .reti       (reti),
    .io_addr    (io_addr),
    .io_wr      (io_wr),
    .io_wdata   (io_wdata),
    .io_rdata   (io_rdata),
    .irq        (irq),
    .vector     (vector),
    .in_service (in_service)
  );

  interrupt_controller #(.NUM_IRQ(4)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .irq_lines  (irq_lines[3:0]),
    .sreg_i     (sreg_i),
    .irq_ack    (irq_ack),
    .reti       (reti),
    .io_addr    (io_addr),
    .io_wr      (io_wr),
    .io_wdata   (io_wdata),
    .io_rdata   (io_rdata4),
    .irq        (irq4),
    .vector     (vector4),
    .in_service (in_service4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int modelRead();
    int v = 0;
    for (int i = 0; i < 8; i++) begin
      if (io_addr == 6'h39 && m_mask[i]) v |= (1 << i);
      if (io_addr == 6'h38 && m_flag[i]) v |= (1 << i);
    end
    return v;
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic modelUpdate();
    int  win;
    bit  ack_now;
    win = -1;
    for (int i = 7; i >= 0; i--) if (m_flag[i] && m_mask[i]) win = i;
    ack_now = m_irq && irq_ack;
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        m_prev[i] = irq_lines[i];
        m_flag[i] = 1'b0;
        m_mask[i] = 1'b0;
      end
      m_irq = 0; m_svc = 0; m_vec = 0; m_idx = 0;
      return;
    end
    for (int i = 0; i < 8; i++) begin
      bit rose;
      bit cleared;
      rose    = irq_lines[i] && !m_prev[i];
      cleared = (io_wr && io_addr == 6'h38 && io_wdata[i]) || (ack_now && i == m_idx);
      m_flag[i] = rose || (m_flag[i] && !cleared);
      if (io_wr && io_addr == 6'h39) m_mask[i] = io_wdata[i];
      m_prev[i] = irq_lines[i];
    end
    if (m_irq) begin
      if (irq_ack) begin
        m_irq = 0;
        m_svc = 1;
      end
    end else if (m_svc) begin
      if (reti) m_svc = 0;
    end else if (sreg_i && win >= 0) begin
      m_irq = 1;
      m_idx = win;
      m_vec = 1 + win;
    end
  endtask

  task automatic step();
    @(posedge clk);
    modelUpdate();
    #1;
    checkOutput("irq", {31'd0, irq}, {31'd0, m_irq});
    checkOutput("in_service", {31'd0, in_service}, {31'd0, m_svc});
    if (m_irq) checkOutput("vector", {20'd0, vector}, m_vec);
    checkOutput("io_rdata", {24'd0, io_rdata}, modelRead());
  endtask

  task automatic applyStimulus(input logic [7:0] lines, input logic sreg,
                               input logic ack, input logic rt, input logic wr,
                               input logic [5:0] addr, input logic [7:0] wdata,
                               input logic rst);
    irq_lines = lines;
    sreg_i    = sreg;
    irq_ack   = ack;
    reti      = rt;
    io_wr     = wr;
    io_addr   = addr;
    io_wdata  = wdata;
    reset     = rst;
    step();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    irq_lines = '0; sreg_i = 0; irq_ack = 0; reti = 0;
    io_addr = '0; io_wr = 0; io_wdata = '0; reset = 1;
    m_irq = 0; m_svc = 0; m_idx = 0; m_vec = 0;
    for (int i = 0; i < 8; i++) begin
      m_flag[i] = 0; m_mask[i] = 0; m_prev[i] = 0;
    end

    applyStimulus(8'h00, 1, 0, 0, 0, 6'h38, 8'h00, 1);
    applyStimulus(8'h00, 1, 0, 0, 0, 6'h38, 8'h00, 1);
    checkOutput("reset_irq", {31'd0, irq}, 32'd0);
    checkOutput("reset_vector", {20'd0, vector}, 32'd0);
    checkOutput("reset_ifr", {24'd0, io_rdata}, 32'd0);

    // Single line 2, two-cycle latency, ack and reti.
    applyStimulus(8'h00, 1, 0, 0, 1, 6'h39, 8'h04, 0);
    applyStimulus(8'h04, 1, 0, 0, 0, 6'h38, 8'h00, 0);
    checkOutput("tp1_no_irq_yet", {31'd0, irq}, 32'd0);
    applyStimulus(8'h00, 1, 0, 0, 0, 6'h38, 8'h00, 0);
    checkOutput("tp1_irq", {31'd0, irq}, 32'd1);
    checkOutput("tp1_vector", {20'd0, vector}, 32'h003);
    applyStimulus(8'h00, 1, 1, 0, 0, 6'h38, 8'h00, 0);
    checkOutput("tp1_ack_irq", {31'd0, irq}, 32'd0);
    checkOutput("tp1_ack_ifr", {24'd0, io_rdata}, 32'd0);
    checkOutput("tp1_in_service", {31'd0, in_service}, 32'd1);
    applyStimulus(8'h00, 1, 0, 1, 0, 6'h38, 8'h00, 0);
    checkOutput("tp1_reti", {31'd0, in_service}, 32'd0);

    // Lines 5 and 1 together: lowest index first.
    applyStimulus(8'h00, 1, 0, 0, 1, 6'h39, 8'hFF, 0);
    applyStimulus(8'h22, 1, 0, 0, 0, 6'h38, 8'h00, 0);
    applyStimulus(8'h00, 1, 0, 0, 0, 6'h38, 8'h00, 0);
    checkOutput("tp2_first_vector", {20'd0, vector}, 32'h002);
    applyStimulus(8'h00, 1, 1, 0, 0, 6'h38, 8'h00, 0);
    applyStimulus(8'h00, 1, 0, 1, 0, 6'h38, 8'h00, 0);
    applyStimulus(8'h00, 1, 0, 0, 0, 6'h38, 8'h00, 0);
    checkOutput("tp2_second_irq", {31'd0, irq}, 32'd1);
    checkOutput("tp2_second_vector", {20'd0, vector}, 32'h006);
    applyStimulus(8'h00, 1, 1, 0, 0, 6'h38, 8'h00, 0);
    applyStimulus(8'h00, 1, 0, 1, 0, 6'h38, 8'h00, 0);

    // Global enable gating, then committed request.
    applyStimulus(8'h08, 0, 0, 0, 0, 6'h38, 8'h00, 0);
    applyStimulus(8'h00, 0, 0, 0, 0, 6'h38, 8'h00, 0);
    checkOutput("tp3_sreg_off_irq", {31'd0, irq}, 32'd0);
    checkOutput("tp3_ifr", {24'd0, io_rdata}, 32'h08);
    applyStimulus(8'h00, 1, 0, 0, 0, 6'h38, 8'h00, 0);
    checkOutput("tp3_sreg_on_irq", {31'd0, irq}, 32'd1);
    applyStimulus(8'h00, 0, 0, 0, 1, 6'h38, 8'hFF, 0);
    checkOutput("tp4_hold_irq", {31'd0, irq}, 32'd1);
    checkOutput("tp4_hold_vector", {20'd0, vector}, 32'h004);
    applyStimulus(8'h01, 0, 1, 0, 0, 6'h38, 8'h00, 0);
    checkOutput("tp4_set_wins", {24'd0, io_rdata}, 32'h01);
    applyStimulus(8'h01, 0, 0, 1, 0, 6'h38, 8'h00, 0);

    // Line held high through reset, then reset during SERVICE.
    applyStimulus(8'h01, 0, 0, 0, 0, 6'h38, 8'h00, 1);
    applyStimulus(8'h01, 0, 0, 0, 0, 6'h38, 8'h00, 0);
    checkOutput("tp5_held_line_no_flag", {24'd0, io_rdata}, 32'h00);
    applyStimulus(8'h00, 0, 0, 0, 0, 6'h38, 8'h00, 0);
    applyStimulus(8'h01, 0, 0, 0, 0, 6'h38, 8'h00, 0);
    checkOutput("tp5_new_pulse_flag", {24'd0, io_rdata}, 32'h01);
    applyStimulus(8'h00, 1, 0, 0, 1, 6'h39, 8'h01, 0);
    applyStimulus(8'h00, 1, 0, 0, 0, 6'h38, 8'h00, 0);
    applyStimulus(8'h00, 1, 1, 0, 0, 6'h38, 8'h00, 0);
    checkOutput("tp5_in_service", {31'd0, in_service}, 32'd1);
    applyStimulus(8'h00, 1, 0, 0, 0, 6'h38, 8'h00, 1);
    checkOutput("tp5_reset_svc", {31'd0, in_service}, 32'd0);
    applyStimulus(8'h00, 1, 0, 1, 0, 6'h38, 8'h00, 0);
    checkOutput("tp5_reti_ignored", {31'd0, in_service}, 32'd0);
    checkOutput("tp5_no_irq", {31'd0, irq}, 32'd0);

    // Mask width limiting and unmapped reads.
    applyStimulus(8'h00, 0, 0, 0, 1, 6'h39, 8'hFF, 0);
    checkOutput("tp6_imsk4", {24'd0, io_rdata4}, 32'h0F);
    checkOutput("tp6_imsk8", {24'd0, io_rdata}, 32'hFF);
    applyStimulus(8'h00, 0, 0, 0, 0, 6'h10, 8'h00, 0);
    checkOutput("tp6_unmapped", {24'd0, io_rdata}, 32'h00);
    checkOutput("tp6_unmapped4", {24'd0, io_rdata4}, 32'h00);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] lines;
      logic [5:0] addr;
      logic       wr;
      int         sel;
      lines = irq_lines ^ 8'($urandom & $urandom & $urandom);
      sel   = $urandom_range(0, 3);
      addr  = (sel == 0) ? 6'h39 : (sel == 3) ? 6'($urandom) : 6'h38;
      wr    = ($urandom_range(0, 9) == 0);
      applyStimulus(lines, ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0), wr, addr, 8'($urandom),
                    ($urandom_range(0, 199) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
